// File: rtl/nios_system_button_in_if.sv
`default_nettype none
// ============================================================================
// Module  : nios_system_button_in_if
// Purpose : Avalon-MM slave bus bundle for the button input PIO.
// Rev     : 1.0  initial release
// ============================================================================
interface nios_system_button_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface
`default_nettype wire

// File: rtl/nios_system_button_in.sv
`default_nettype none
// ============================================================================
// Module  : nios_system_button_in
// Purpose : Synchronised, debounced input PIO with edge capture and masked IRQ.
// Rev     : 1.0  initial release
// ============================================================================
module nios_system_button_in #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    nios_system_button_in_if.slave bus,
    input  wire logic [WIDTH-1:0]  in_port
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] c_cnt_max  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]    c_addr_dat = 2'd0;
    localparam logic [1:0]    c_addr_msk = 2'd2;
    localparam logic [1:0]    c_addr_cap = 2'd3;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] w_db;
    logic [WIDTH-1:0] r_db_d;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_mux;
    logic [31:0]      r_readdata;
    logic             w_wr;

    assign w_wr = bus.chipselect && !bus.write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_db_d <= '0;
        end else begin
            r_s1   <= in_port;
            r_s2   <= r_s1;
            r_db_d <= w_db;
        end
    end

    // Each bit owns its counter so a bouncing bit never delays its neighbours.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] r_cnt;
        logic          r_db;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= '0;
                r_db  <= 1'b0;
            end else if (r_s2[i] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_db  <= r_s2[i];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_db[i] = r_db;
    end

    if (EDGE_TYPE == 0) begin : g_rise
        assign w_edge = w_db & ~r_db_d;
    end else if (EDGE_TYPE == 1) begin : g_fall
        assign w_edge = ~w_db & r_db_d;
    end else begin : g_any
        assign w_edge = w_db ^ r_db_d;
    end

    assign w_clr = (w_wr && bus.address == c_addr_cap) ? bus.writedata[WIDTH-1:0] : '0;

    // A new edge outranks a simultaneous clear so no event is ever lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap  <= '0;
            r_mask <= '0;
        end else begin
            r_cap <= (r_cap & ~w_clr) | w_edge;
            if (w_wr && bus.address == c_addr_msk) begin
                r_mask <= bus.writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            c_addr_dat: w_rd_mux = 32'(w_db);
            c_addr_msk: w_rd_mux = 32'(r_mask);
            c_addr_cap: w_rd_mux = 32'(r_cap);
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= bus.chipselect ? w_rd_mux : 32'd0;
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = |(r_cap & r_mask);
endmodule
`default_nettype wire
